layer_bias_act_stage: RTL and testbench
=======================================

# layer_bias_act_stage

Post-accumulate stage for one dense layer of the MNIST engine. Consumes per-neuron dot-product accumulations in neuron order and adds the matching bias word from the AXI4-Lite register bank. Applies fixed-point rescale, optional ReLU and saturation, and streams results downstream. Tracks the running argmax and reports busy, done, error and argmax on the status word that the register bank reads back.

## Interface
- NUM_NEURONS, 18: neurons per pass; equals the bias register count.
- FRAC_SHIFT, 8: arithmetic right shift applied after the bias add.
- OUT_W, 16: signed output width.
- aclk  in  1  sole clock; all logic is on its rising edge.
- areset  in  1  synchronous, active-high reset.
- bias_flat  in  32*NUM_NEURONS  signed biases; neuron i occupies bits [32i+31:32i].
- control  in  32  [0] start (rising edge), [1] relu_en, [2] abort (level); other bits ignored.
- status  out  32  [0] busy, [1] done, [2] sat_flag, [3] seq_err, [12:8] argmax index, others 0.
- s_acc_tdata  in  32  signed accumulation for the current neuron.
- s_acc_tvalid / s_acc_tready  in / out  1  input handshake.
- s_acc_tlast  in  1  marks the final neuron of the pass.
- m_out_tdata  out  OUT_W  activated result.
- m_out_tuser  out  5  neuron index of m_out_tdata.
- m_out_tvalid / m_out_tready  out / in  1  output handshake.
- m_out_tlast  out  1  high with the result for index NUM_NEURONS-1.

## Operation
- FSM has three states: IDLE, RUN, DRAIN.
- IDLE to RUN on a start edge (control[0] is 1 now and was 0 on the previous cycle). Entering RUN sets idx=0, busy=1, and clears done, sat_flag, seq_err and argmax.
- An edge-detect register captures control[0] every cycle, including when the edge is ignored.
- RUN: each input beat accepted (tvalid&tready) is processed as follows.
  - sum = sext33(tdata) + sext33(bias[idx]).
  - v = sum >>> FRAC_SHIFT.
  - If relu_en=1 and v<0, then v=0.
  - Clamp v to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Set sat_flag (sticky) if the clamp engages.
- Argmax updates on acceptance only if v > the current max (strict compare). Ties keep the lower index. Index 0 always loads the max.
- seq_err (sticky) sets if tlast=1 with idx≠NUM_NEURONS-1, or tlast=0 with idx=NUM_NEURONS-1. The count is driven by idx, never by tlast.
- After accepting idx=NUM_NEURONS-1: go to DRAIN and hold s_acc_tready=0.
- DRAIN to IDLE when the last output beat is accepted. In the same cycle done=1 and busy=0.
- done stays 1 until the next start. Argmax holds until the next start.
- A start edge in RUN or DRAIN is ignored.
- abort=1, in any state, forces IDLE, drops any pending output (m_out_tvalid=0) and clears busy. done, sat_flag, seq_err and argmax are left as they are.
- abort and a start edge in the same cycle: abort wins and the start is lost.
- s_acc_tready = 0 in IDLE and DRAIN.

## Timing
- Reset values: status=0, m_out_tvalid=0, m_out_tdata=0, m_out_tuser=0, m_out_tlast=0, s_acc_tready=0, FSM=IDLE, edge register=0.
- s_acc_tready is 1 in RUN when (!m_out_tvalid || m_out_tready). This gives one result register with full throughput.
- Latency: a beat accepted at cycle N appears on m_out_* at cycle N+1.
- m_out_* hold stable while tvalid=1 and tready=0.
- Sustained throughput is 1 beat per cycle with m_out_tready held at 1.
- busy rises the cycle after the start edge. The first s_acc_tready can also be high that cycle.
- Status fields are registered and update one cycle after the event that causes them.
- areset mid-pass: the next cycle shows reset values. No partial result is emitted afterwards.
- A relu_en change during a pass takes effect on the next accepted beat.

## Test plan
- relu_en=1, bias[i]=i<<8, acc[i]=256·(i-9), tready=1 -> out[i]=max(0,2i-9) for i≥5, 0 for i<5, argmax=17, done=1, sat_flag=0, seq_err=0.
- relu_en=0, bias[3]=0x7FFF0000, acc[3]=0x7FFF0000 -> out[3]=0x7FFF, sat_flag=1. Separately, acc=0x80000000 with bias=0x80000000 gives -32768.
- Random m_out_tready (50%) with a continuous input stream -> no beat lost or duplicated, output order and tuser 0..17, tlast only on index 17.
- tlast asserted on index 5, and omitted on index 17 -> seq_err=1, all 18 outputs still produced, done=1.
- abort raised after 7 accepted beats -> m_out_tvalid=0 next cycle, busy=0, done=0. A following start runs a clean full 18-beat pass.
- Start held high across two passes (no new edge) -> second pass does not start. Equal maxima at indices 2 and 9 -> argmax=2.

Source files
------------

// File: rtl/layer_bias_act_stage.sv
// Post-accumulate stage for one dense layer: bias add, fixed-point rescale,
// optional ReLU, saturation, output streaming and running argmax/status.
module layer_bias_act_stage #(
    parameter int unsigned NUM_NEURONS = 18,
    parameter int unsigned FRAC_SHIFT  = 8,
    parameter int unsigned OUT_W       = 16
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [32*NUM_NEURONS-1:0] bias_flat,
    input  logic [31:0]               control,
    output logic [31:0]               status,
    input  logic [31:0]               s_acc_tdata,
    input  logic                      s_acc_tvalid,
    output logic                      s_acc_tready,
    input  logic                      s_acc_tlast,
    output logic [OUT_W-1:0]          m_out_tdata,
    output logic [4:0]                m_out_tuser,
    output logic                      m_out_tvalid,
    input  logic                      m_out_tready,
    output logic                      m_out_tlast
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_e;

    localparam logic [4:0] LAST_IDX = 5'(NUM_NEURONS - 1);
    localparam logic signed [32:0] OUT_MAX = $signed({{(34-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}});
    localparam logic signed [32:0] OUT_MIN = $signed({{(34-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}});

    state_e             state_q;
    logic               start_prev_q;
    logic [4:0]         idx_q;
    logic               busy_q;
    logic               done_q;
    logic               sat_q;
    logic               seqerr_q;
    logic [4:0]         argmax_q;
    logic [OUT_W-1:0]   max_q;
    logic [OUT_W-1:0]   out_data_q;
    logic [4:0]         out_user_q;
    logic               out_last_q;
    logic               out_valid_q;

    logic               start_edge;
    logic               abort;
    logic               relu_en;
    logic               accept;
    logic               out_fire;
    logic               idx_is_last;
    logic [31:0]        bias_sel;
    logic signed [32:0] sum;
    logic signed [32:0] shifted;
    logic signed [32:0] act;
    logic [OUT_W-1:0]   res_d;
    logic               clip_d;
    logic               new_max_d;
    logic               unused_ctrl;

    assign start_edge  = control[0] & ~start_prev_q;
    assign relu_en     = control[1];
    assign abort       = control[2];
    assign unused_ctrl = ^control[31:3];

    assign s_acc_tready = (state_q == ST_RUN) && (!out_valid_q || m_out_tready);
    assign accept       = s_acc_tvalid && s_acc_tready;
    assign out_fire     = out_valid_q && m_out_tready;
    assign idx_is_last  = (idx_q == LAST_IDX);

    always_comb begin
        bias_sel = '0;
        for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
            if (idx_q == 5'(i)) begin
                bias_sel = bias_flat[32*i +: 32];
            end
        end
    end

    // 33-bit sum so two full-scale 32-bit operands can never wrap before the shift
    always_comb begin
        sum     = $signed({s_acc_tdata[31], s_acc_tdata}) + $signed({bias_sel[31], bias_sel});
        shifted = sum >>> FRAC_SHIFT;
        if (relu_en && shifted[32]) begin
            act = '0;
        end else begin
            act = shifted;
        end
        clip_d = 1'b0;
        if (act > OUT_MAX) begin
            res_d  = OUT_MAX[OUT_W-1:0];
            clip_d = 1'b1;
        end else if (act < OUT_MIN) begin
            res_d  = OUT_MIN[OUT_W-1:0];
            clip_d = 1'b1;
        end else begin
            res_d = act[OUT_W-1:0];
        end
        new_max_d = (idx_q == '0) || ($signed(res_d) > $signed(max_q));
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b0;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sat_q        <= 1'b0;
            seqerr_q     <= 1'b0;
            argmax_q     <= '0;
            max_q        <= '0;
            out_data_q   <= '0;
            out_user_q   <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            start_prev_q <= control[0];
            if (abort) begin
                state_q     <= ST_IDLE;
                out_valid_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_edge) begin
                            state_q  <= ST_RUN;
                            idx_q    <= '0;
                            busy_q   <= 1'b1;
                            done_q   <= 1'b0;
                            sat_q    <= 1'b0;
                            seqerr_q <= 1'b0;
                            argmax_q <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (out_fire) begin
                            out_valid_q <= 1'b0;
                        end
                        if (accept) begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= res_d;
                            out_user_q  <= idx_q;
                            out_last_q  <= idx_is_last;
                            if (clip_d) begin
                                sat_q <= 1'b1;
                            end
                            if (s_acc_tlast != idx_is_last) begin
                                seqerr_q <= 1'b1;
                            end
                            if (new_max_d) begin
                                max_q    <= res_d;
                                argmax_q <= idx_q;
                            end
                            // neuron count alone ends the pass; tlast only feeds seq_err
                            if (idx_is_last) begin
                                state_q <= ST_DRAIN;
                            end else begin
                                idx_q <= idx_q + 5'd1;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (out_fire) begin
                            out_valid_q <= 1'b0;
                            if (out_last_q) begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign m_out_tdata  = out_data_q;
    assign m_out_tuser  = out_user_q;
    assign m_out_tlast  = out_last_q;
    assign m_out_tvalid = out_valid_q;
    assign status       = {19'd0, argmax_q, 4'd0, seqerr_q, sat_q, done_q, busy_q};

endmodule

// File: tb/tb_layer_bias_act_stage.sv
// Directed bench for layer_bias_act_stage: table-driven passes plus abort,
// reset and start-edge corner sequences.
module tb_layer_bias_act_stage;

    localparam int NN = 18;

    logic              aclk = 1'b0;
    logic              areset;
    logic [32*NN-1:0]  bias_flat;
    logic [31:0]       control;
    logic [31:0]       status;
    logic [31:0]       s_acc_tdata;
    logic              s_acc_tvalid;
    logic              s_acc_tready;
    logic              s_acc_tlast;
    logic [15:0]       m_out_tdata;
    logic [4:0]        m_out_tuser;
    logic              m_out_tvalid;
    logic              m_out_tready;
    logic              m_out_tlast;

    layer_bias_act_stage #(
        .NUM_NEURONS(NN),
        .FRAC_SHIFT (8),
        .OUT_W      (16)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .bias_flat   (bias_flat),
        .control     (control),
        .status      (status),
        .s_acc_tdata (s_acc_tdata),
        .s_acc_tvalid(s_acc_tvalid),
        .s_acc_tready(s_acc_tready),
        .s_acc_tlast (s_acc_tlast),
        .m_out_tdata (m_out_tdata),
        .m_out_tuser (m_out_tuser),
        .m_out_tvalid(m_out_tvalid),
        .m_out_tready(m_out_tready),
        .m_out_tlast (m_out_tlast)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] acc;
        logic [31:0] bias;
        logic [15:0] exp;
    } vec_t;

    vec_t        tbl [NN];
    logic [31:0] acc_v [NN];
    logic        last_v [NN];
    logic [15:0] exp_data [NN];
    logic [15:0] got_data [NN];
    logic [4:0]  got_user [NN];
    logic        got_last [NN];
    int          n_got;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic start_edge();
        tick();
        control[0] = 1'b0;
        tick();
        control[0] = 1'b1;
        tick();
    endtask

    task automatic run_pass(input string tag, input bit rnd);
        int in_i;
        int cyc;
        in_i  = 0;
        n_got = 0;
        cyc   = 0;
        for (int i = 0; i < NN; i++) begin
            got_data[i] = 'x;
            got_user[i] = 'x;
            got_last[i] = 1'bx;
        end
        start_edge();
        chk({tag, "_busy_rise"}, {31'd0, status[0]}, 32'd1);
        while (n_got < NN && cyc < 400) begin
            s_acc_tvalid = (in_i < NN);
            s_acc_tdata  = (in_i < NN) ? acc_v[in_i] : 32'd0;
            s_acc_tlast  = (in_i < NN) ? last_v[in_i] : 1'b0;
            m_out_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge aclk);
            if (s_acc_tvalid && s_acc_tready) in_i++;
            if (m_out_tvalid && m_out_tready) begin
                got_data[n_got] = m_out_tdata;
                got_user[n_got] = m_out_tuser;
                got_last[n_got] = m_out_tlast;
                n_got++;
            end
            tick();
            cyc++;
        end
        s_acc_tvalid = 1'b0;
        m_out_tready = 1'b0;
        if (cyc >= 400) chk({tag, "_timeout"}, 32'(cyc), 32'd0);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_count"}, 32'(n_got), 32'(NN));
        for (int i = 0; i < NN; i++) begin
            chk($sformatf("%s_data[%0d]", tag, i), {16'd0, got_data[i]}, {16'd0, exp_data[i]});
            chk($sformatf("%s_user[%0d]", tag, i), {27'd0, got_user[i]}, 32'(i));
            chk($sformatf("%s_last[%0d]", tag, i), {31'd0, got_last[i]}, (i == NN-1) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic load_relu_pass();
        control[1] = 1'b1;
        for (int i = 0; i < NN; i++) begin
            bias_flat[32*i +: 32] = 32'(i) << 8;
            acc_v[i]    = 32'(256 * (i - 9));
            last_v[i]   = (i == NN-1);
            exp_data[i] = (2*i - 9 > 0) ? 16'(2*i - 9) : 16'd0;
        end
    endtask

    initial begin
        bit saw_valid;
        int acc_cnt;

        // relu_en=0 vectors: rounding toward -inf, clamp boundaries, 33-bit sum headroom
        tbl[0]  = '{32'h0000_0100, 32'h0000_0000, 16'h0001};
        tbl[1]  = '{32'hFFFF_FF00, 32'h0000_0000, 16'hFFFF};
        tbl[2]  = '{32'hFFFF_FFFF, 32'h0000_0000, 16'hFFFF};
        tbl[3]  = '{32'h7FFF_0000, 32'h7FFF_0000, 16'h7FFF};
        tbl[4]  = '{32'h8000_0000, 32'h8000_0000, 16'h8000};
        tbl[5]  = '{32'h007F_FF00, 32'h0000_0000, 16'h7FFF};
        tbl[6]  = '{32'h0080_0000, 32'h0000_0000, 16'h7FFF};
        tbl[7]  = '{32'hFF80_0000, 32'h0000_0000, 16'h8000};
        tbl[8]  = '{32'h0000_1234, 32'h0000_0100, 16'h0013};
        tbl[9]  = '{32'hFFFF_F000, 32'h0000_0080, 16'hFFF0};
        tbl[10] = '{32'h0001_0000, 32'hFFFF_0000, 16'h0000};
        tbl[11] = '{32'h7FFF_FFFF, 32'h0000_0001, 16'h7FFF};
        tbl[12] = '{32'h0000_2000, 32'h0000_0000, 16'h0020};
        tbl[13] = '{32'h0000_0000, 32'hFFFF_FF01, 16'hFFFF};
        tbl[14] = '{32'h0005_0000, 32'h0003_0000, 16'h0800};
        tbl[15] = '{32'h0000_0000, 32'h0000_0000, 16'h0000};
        tbl[16] = '{32'h0000_7F00, 32'h0000_0000, 16'h007F};
        tbl[17] = '{32'h0000_00FF, 32'h0000_0000, 16'h0000};

        areset       = 1'b1;
        control      = 32'd0;
        bias_flat    = '0;
        s_acc_tdata  = 32'd0;
        s_acc_tvalid = 1'b0;
        s_acc_tlast  = 1'b0;
        m_out_tready = 1'b0;
        repeat (3) tick();
        chk("rst_status", status, 32'd0);
        chk("rst_tvalid", {31'd0, m_out_tvalid}, 32'd0);
        chk("rst_tdata",  {16'd0, m_out_tdata}, 32'd0);
        chk("rst_tuser",  {27'd0, m_out_tuser}, 32'd0);
        chk("rst_tlast",  {31'd0, m_out_tlast}, 32'd0);
        chk("rst_tready", {31'd0, s_acc_tready}, 32'd0);
        areset = 1'b0;
        tick();

        // Pass A: ReLU ramp, argmax lands on the last neuron
        load_relu_pass();
        run_pass("A", 1'b0);
        check_outputs("A");
        chk("A_status", status, 32'h0000_1102);

        // start still held high: no new edge, so nothing restarts
        s_acc_tvalid = 1'b1;
        repeat (4) tick();
        chk("held_busy", {31'd0, status[0]}, 32'd0);
        chk("held_tready", {31'd0, s_acc_tready}, 32'd0);
        chk("held_done", {31'd0, status[1]}, 32'd1);
        s_acc_tvalid = 1'b0;

        // Pass B: table vectors with 50% output back-pressure
        control[1] = 1'b0;
        for (int i = 0; i < NN; i++) begin
            bias_flat[32*i +: 32] = tbl[i].bias;
            acc_v[i]    = tbl[i].acc;
            last_v[i]   = (i == NN-1);
            exp_data[i] = tbl[i].exp;
        end
        run_pass("B", 1'b1);
        check_outputs("B");
        chk("B_status", status, 32'h0000_0306);

        // Pass C: tied maxima at 2 and 9, tlast misplaced on 5 and missing on 17
        for (int i = 0; i < NN; i++) begin
            bias_flat[32*i +: 32] = 32'd0;
            acc_v[i]    = (i == 2 || i == 9) ? 32'h0000_6400 : 32'(i) << 8;
            last_v[i]   = (i == 5);
            exp_data[i] = (i == 2 || i == 9) ? 16'd100 : 16'(i);
        end
        run_pass("C", 1'b0);
        check_outputs("C");
        chk("C_status", status, 32'h0000_020A);

        // Abort after 7 accepted beats while an output is pending
        load_relu_pass();
        start_edge();
        acc_cnt = 0;
        for (int cyc = 0; cyc < 100 && acc_cnt < 7; cyc++) begin
            s_acc_tvalid = 1'b1;
            s_acc_tdata  = acc_v[acc_cnt];
            s_acc_tlast  = 1'b0;
            m_out_tready = 1'b1;
            @(negedge aclk);
            if (s_acc_tvalid && s_acc_tready) acc_cnt++;
            tick();
        end
        chk("abort_accepted", 32'(acc_cnt), 32'd7);
        control[2]   = 1'b1;
        s_acc_tvalid = 1'b0;
        m_out_tready = 1'b0;
        tick();
        chk("abort_tvalid", {31'd0, m_out_tvalid}, 32'd0);
        chk("abort_status", status, 32'h0000_0600);
        chk("abort_tready", {31'd0, s_acc_tready}, 32'd0);
        control[2] = 1'b0;
        run_pass("D", 1'b0);
        check_outputs("D");
        chk("D_status", status, 32'h0000_1102);

        // Abort coinciding with a start edge: the start is lost
        control[0] = 1'b0;
        tick();
        control[0] = 1'b1;
        control[2] = 1'b1;
        tick();
        chk("abst_busy0", {31'd0, status[0]}, 32'd0);
        control[2] = 1'b0;
        tick();
        tick();
        chk("abst_busy1", {31'd0, status[0]}, 32'd0);
        chk("abst_done", {31'd0, status[1]}, 32'd1);

        // Reset mid-pass: reset values next cycle and no stray output afterwards
        start_edge();
        acc_cnt = 0;
        for (int cyc = 0; cyc < 100 && acc_cnt < 3; cyc++) begin
            s_acc_tvalid = 1'b1;
            s_acc_tdata  = acc_v[acc_cnt];
            m_out_tready = 1'b1;
            @(negedge aclk);
            if (s_acc_tvalid && s_acc_tready) acc_cnt++;
            tick();
        end
        areset     = 1'b1;
        control[0] = 1'b0;
        tick();
        chk("mrst_status", status, 32'd0);
        chk("mrst_tvalid", {31'd0, m_out_tvalid}, 32'd0);
        chk("mrst_tdata",  {16'd0, m_out_tdata}, 32'd0);
        chk("mrst_tready", {31'd0, s_acc_tready}, 32'd0);
        areset       = 1'b0;
        s_acc_tvalid = 1'b0;
        saw_valid    = 1'b0;
        repeat (5) begin
            tick();
            if (m_out_tvalid) saw_valid = 1'b1;
        end
        chk("mrst_no_output", {31'd0, saw_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
